// File: rtl/lc3_mem_arbiter_if.sv
// Bus bundle for the LC3 memory arbiter: CPU and DMA request ports plus the shared memory port.
// master = requesters and memory array, slave = the arbiter itself.
interface lc3_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rdy;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rdy;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              owner;
  logic              busy;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_rdy,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_rdy,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner, busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_rdy,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_rdy,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner, busy
  );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Two-requester (CPU/DMA) arbiter for the single LC3 memory port, one access at a time.
// Define LC3_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the CPU has fixed priority.
module lc3_mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  lc3_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              cpu_rdy_q, cpu_rdy_d;
  logic              dma_rdy_q, dma_rdy_d;
  logic              grant_dma;
  logic              any_req;

`ifdef LC3_ARB_ROUND_ROBIN_EN
  // 1 = DMA wins the next tie; always points at the loser of the last grant.
  logic              rr_q, rr_d;
  assign grant_dma = bus.dma_req & (~bus.cpu_req | rr_q);
`else
  assign grant_dma = bus.dma_req & ~bus.cpu_req;
`endif

  assign any_req = bus.cpu_req | bus.dma_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_rdy_q   <= 1'b0;
      dma_rdy_q   <= 1'b0;
`ifdef LC3_ARB_ROUND_ROBIN_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_rdy_q   <= cpu_rdy_d;
      dma_rdy_q   <= dma_rdy_d;
`ifdef LC3_ARB_ROUND_ROBIN_EN
      rr_q        <= rr_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    owner_d     = owner_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_rdy_d   = 1'b0;
    dma_rdy_d   = 1'b0;
`ifdef LC3_ARB_ROUND_ROBIN_EN
    rr_d        = rr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d = grant_dma;
          we_d    = grant_dma ? bus.dma_we    : bus.cpu_we;
          addr_d  = grant_dma ? bus.dma_addr  : bus.cpu_addr;
          wdata_d = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
          cnt_d   = CNT_LOAD;
          state_d = S_ACCESS;
`ifdef LC3_ARB_ROUND_ROBIN_EN
          rr_d    = ~grant_dma;
`endif
        end
      end

      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          // rdy and rdata register together so both appear in the DONE cycle.
          if (!we_q) begin
            if (owner_q) dma_rdata_d = bus.mem_rdata;
            else         cpu_rdata_d = bus.mem_rdata;
          end
          if (owner_q) dma_rdy_d = 1'b1;
          else         cpu_rdy_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.mem_en    = (state_q == S_ACCESS);
  assign bus.mem_we    = (state_q == S_ACCESS) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.cpu_rdy   = cpu_rdy_q;
  assign bus.dma_rdy   = dma_rdy_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: main instance with WAIT_CYCLES=2 plus a WAIT_CYCLES=1 instance.
// Read results are queued when requested and popped when the matching rdy pulse appears.
module tb_lc3_mem_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  typedef struct packed {
    logic        side;
    logic [15:0] data;
  } exp_t;

  exp_t sb_q[$];

  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model for the main instance; preload port shares the single write process.
  logic [15:0] mem [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [15:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  assign bus.mem_rdata  = mem[bus.mem_addr];
  assign bus1.mem_rdata = bus1.mem_addr ^ 16'h5A5A;

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic drive(input logic side, input logic req, input logic we,
                       input logic [15:0] a, input logic [15:0] d);
    if (side) begin
      bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
  endtask

  // Issues one access and returns the cycle of its rdy pulse (-1 on timeout).
  task automatic do_access(input logic side, input logic we, input logic [15:0] a,
                           input logic [15:0] d, output int lat, output logic [15:0] rd);
    lat = -1;
    rd  = 'x;
    @(posedge clk); #1;
    drive(side, 1'b1, we, a, d);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (side ? bus.dma_rdy : bus.cpu_rdy) begin
        lat = c;
        rd  = side ? bus.dma_rdata : bus.cpu_rdata;
        break;
      end
    end
    drive(side, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.mem_en, bus.mem_we, bus.cpu_rdy, bus.dma_rdy, bus.busy, bus.owner} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.mem_en, bus.mem_we, bus.cpu_rdy, bus.dma_rdy, bus.busy, bus.owner});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dma_rdata} !== 64'h0) begin
      bad++;
      $display("FAIL reset_data: got %h expected 0",
               {bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dma_rdata});
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_busy: got %b expected 0", bus.busy);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_cpu_read;
    logic [2:0] exp_v [0:4];
    exp_t       e;
    exp_v[0] = 3'b000; exp_v[1] = 3'b101; exp_v[2] = 3'b101;
    exp_v[3] = 3'b011; exp_v[4] = 3'b000;
    preload(16'h3000, 16'h1234);
    sb_q.push_back('{side: 1'b0, data: 16'h1234});
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 16'h3000, 16'h0000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({bus.mem_en, bus.cpu_rdy, bus.busy} !== exp_v[c]) begin
        bad++;
        $display("FAIL cpu_read_cycle%0d: en/rdy/busy got %b expected %b",
                 c, {bus.mem_en, bus.cpu_rdy, bus.busy}, exp_v[c]);
      end
      if (c == 1) begin
        total++;
        if (bus.mem_addr !== 16'h3000) begin
          bad++;
          $display("FAIL cpu_read_addr: got %h expected 3000", bus.mem_addr);
        end
      end
      if (bus.cpu_rdy === 1'b1) begin
        e = sb_q.pop_front();
        total++;
        if (bus.cpu_rdata !== e.data) begin
          bad++;
          $display("FAIL cpu_read_data: got %h expected %h", bus.cpu_rdata, e.data);
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      end
    end
    $display("cpu_read: x3000 -> %h", bus.cpu_rdata);
  endtask

  task automatic test_dma_write;
    int          lat;
    logic [15:0] rd;
    exp_t        e;
    preload(16'h0005, 16'h5555);
    sb_q.push_back('{side: 1'b1, data: 16'h5555});
    do_access(1'b1, 1'b0, 16'h0005, 16'h0000, lat, rd);
    e = sb_q.pop_front();
    total++;
    if (rd !== e.data || lat != 3) begin
      bad++;
      $display("FAIL dma_read: data %h lat %0d expected %h lat 3", rd, lat, e.data);
    end
    do_access(1'b1, 1'b1, 16'h4000, 16'hBEEF, lat, rd);
    total++;
    if (rd !== 16'h5555 || lat != 3 || bus.owner !== 1'b1) begin
      bad++;
      $display("FAIL dma_write: rdata %h lat %0d owner %b expected 5555 lat 3 owner 1",
               rd, lat, bus.owner);
    end
    total++;
    if (mem[16'h4000] !== 16'hBEEF) begin
      bad++;
      $display("FAIL dma_write_mem: got %h expected beef", mem[16'h4000]);
    end
    sb_q.push_back('{side: 1'b0, data: 16'hBEEF});
    do_access(1'b0, 1'b0, 16'h4000, 16'h0000, lat, rd);
    e = sb_q.pop_front();
    total++;
    if (rd !== e.data || bus.dma_rdata !== 16'h5555 || bus.owner !== 1'b0) begin
      bad++;
      $display("FAIL cpu_after_dma: cpu %h dma %h owner %b expected %h 5555 0",
               rd, bus.dma_rdata, bus.owner, e.data);
    end
    $display("dma_write: x4000 <- beef, cpu read back %h", rd);
  endtask

  task automatic test_simultaneous;
    int   k;
    exp_t e;
    preload(16'h0100, 16'hC0C0);
    preload(16'h0200, 16'hD0D0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
`ifdef LC3_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++)
      sb_q.push_back(i[0] ? exp_t'('{side: 1'b1, data: 16'hD0D0})
                          : exp_t'('{side: 1'b0, data: 16'hC0C0}));
`else
    for (int i = 0; i < 4; i++) sb_q.push_back('{side: 1'b0, data: 16'hC0C0});
    sb_q.push_back('{side: 1'b1, data: 16'hD0D0});
`endif
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000);
    drive(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000);
    k = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.cpu_rdy === 1'b1 || bus.dma_rdy === 1'b1) begin
        e = sb_q.pop_front();
        total++;
        if ({bus.cpu_rdy, bus.dma_rdy} !== {~e.side, e.side} || bus.owner !== e.side ||
            c != 3 + 4 * k ||
            (e.side ? bus.dma_rdata : bus.cpu_rdata) !== e.data) begin
          bad++;
          $display("FAIL simul_grant%0d: rdy %b owner %b cycle %0d data %h expected side %b cycle %0d data %h",
                   k, {bus.cpu_rdy, bus.dma_rdy}, bus.owner, c,
                   e.side ? bus.dma_rdata : bus.cpu_rdata, e.side, 3 + 4 * k, e.data);
        end
        $display("simultaneous: grant %0d to %s at cycle %0d", k, e.side ? "dma" : "cpu", c);
        k++;
        if (k == 4) bus.cpu_req = 1'b0;
        if (sb_q.size() == 0) begin
          drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
          drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
          break;
        end
      end
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL simul_timeout: %0d grants outstanding expected 0", sb_q.size());
      sb_q.delete();
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
  endtask

  task automatic test_input_change;
    exp_t e;
    preload(16'h0010, 16'hAAAA);
    preload(16'h0020, 16'hBBBB);
    sb_q.push_back('{side: 1'b0, data: 16'hAAAA});
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h1111);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'hDEAD);
    for (int c = 1; c < 6; c++) begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin
        total++;
        if (bus.mem_addr !== 16'h0010 || bus.mem_we !== 1'b0) begin
          bad++;
          $display("FAIL chg_latch_c%0d: addr %h we %b expected 0010 0", c, bus.mem_addr, bus.mem_we);
        end
      end
      if (bus.cpu_rdy === 1'b1) begin
        e = sb_q.pop_front();
        total++;
        if (bus.cpu_rdata !== e.data || c != 3) begin
          bad++;
          $display("FAIL chg_data: got %h cycle %0d expected %h cycle 3", bus.cpu_rdata, c, e.data);
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        break;
      end
    end
    total++;
    if (sb_q.size() != 0 || mem[16'h0020] !== 16'hBBBB) begin
      bad++;
      $display("FAIL chg_outstanding: pending %0d mem20 %h expected 0 bbbb", sb_q.size(), mem[16'h0020]);
      sb_q.delete();
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    $display("input_change: returned %h from x0010", bus.cpu_rdata);
  endtask

  task automatic test_reset_mid;
    int          lat;
    logic [15:0] rd;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 16'h3000, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.mem_en !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_access: mem_en %b expected 1", bus.mem_en);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({bus.mem_en, bus.mem_we, bus.cpu_rdy, bus.dma_rdy, bus.busy, bus.owner,
         bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dma_rdata} !== 70'h0) begin
      bad++;
      $display("FAIL rstmid_zero: ctrl %b addr %h cpu_rdata %h expected all 0",
               {bus.mem_en, bus.mem_we, bus.cpu_rdy, bus.dma_rdy, bus.busy, bus.owner},
               bus.mem_addr, bus.cpu_rdata);
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (bus.cpu_rdy !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_no_rdy%0d: got %b expected 0", c, bus.cpu_rdy);
      end
    end
    rst = 1'b0;
    do_access(1'b0, 1'b0, 16'h3000, 16'h0000, lat, rd);
    total++;
    if (lat != 3 || rd !== 16'h1234) begin
      bad++;
      $display("FAIL rstmid_recover: lat %0d data %h expected 3 1234", lat, rd);
    end
    $display("reset_mid: recovered read lat %0d data %h", lat, rd);
  endtask

  task automatic test_wait1;
    logic [1:0] exp_v [0:3];
    logic [15:0] exp_d;
    exp_v[0] = 2'b00; exp_v[1] = 2'b10; exp_v[2] = 2'b01; exp_v[3] = 2'b00;
    exp_d = 16'h0033 ^ 16'h5A5A;
    @(posedge clk); #1;
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 16'h0033;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({bus1.mem_en, bus1.cpu_rdy} !== exp_v[c]) begin
        bad++;
        $display("FAIL wait1_cycle%0d: en/rdy got %b expected %b", c, {bus1.mem_en, bus1.cpu_rdy}, exp_v[c]);
      end
      if (bus1.cpu_rdy === 1'b1) begin
        total++;
        if (bus1.cpu_rdata !== exp_d) begin
          bad++;
          $display("FAIL wait1_data: got %h expected %h", bus1.cpu_rdata, exp_d);
        end
        bus1.cpu_req = 1'b0;
      end
    end
    bus1.cpu_req = 1'b0;
    $display("wait1: rdata %h", bus1.cpu_rdata);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus1.dma_req = 1'b0; bus1.dma_we = 1'b0; bus1.dma_addr = '0; bus1.dma_wdata = '0;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_simultaneous();
    test_input_change();
    test_reset_mid();
    test_wait1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
